// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encodings,
// default vectors, enable levels and the word-alignment helper.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0050;
  localparam logic        RomEnable      = 1'b1;
  localparam logic        RomDisable     = 1'b0;
  localparam logic [31:0] Zero           = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc_sel.sv
// Next-PC selection: fixed-priority redirect mux with word alignment,
// falling back to the sequential pc+4.
module npc_sel
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] pc,
  input  logic        except_en,
  input  logic        eret_en,
  input  logic [31:0] epc,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        branch_en,
  input  logic [31:0] branch_addr,
  output logic        redirect,
  output logic [31:0] next_pc
);

  always_comb begin
    redirect = 1'b1;
    next_pc  = pc + 32'd4;
    if (except_en) begin
      next_pc = align_word(EXC_VECTOR);
    end else if (eret_en) begin
      next_pc = align_word(epc);
    end else if (jump_en) begin
      next_pc = align_word(jump_addr);
    end else if (branch_en) begin
      next_pc = align_word(branch_addr);
    end else begin
      redirect = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, one-cycle fetch into an output
// register with decode handshake, redirect/flush and stall handling.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        except_en,
  input  logic        eret_en,
  input  logic [31:0] epc,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        branch_en,
  input  logic [31:0] branch_addr,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] npc;
  logic        redirect_req;
  logic        redirect;
  logic        capture;
  logic        hold_cond;

  npc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_npc_sel (
    .pc          (pc_reg),
    .except_en   (except_en),
    .eret_en     (eret_en),
    .epc         (epc),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .redirect    (redirect_req),
    .next_pc     (npc)
  );

  // Redirects are meaningless before the first fetch, so IDLE masks them.
  assign redirect  = redirect_req && (state_reg != S_IDLE);
  assign hold_cond = stall || (inst_valid && !inst_ready);
  assign rom_addr  = pc_reg;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    rom_ce     = RomDisable;
    case (state_reg)
      S_IDLE: state_next = S_RUN;
      S_RUN: begin
        rom_ce  = RomEnable;
        capture = !stall && (!inst_valid || inst_ready);
        if (!redirect && hold_cond) state_next = S_HOLD;
      end
      S_HOLD: begin
        rom_ce = RomEnable;
        if (redirect || !hold_cond) state_next = S_RUN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      pc_reg     <= RESET_PC;
      inst       <= Zero;
      inst_pc    <= Zero;
      inst_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (redirect) begin
        // Flush: whatever was fetched from the old stream is dropped.
        pc_reg     <= npc;
        inst_valid <= 1'b0;
      end else if (capture) begin
        inst       <= rom_data;
        inst_pc    <= pc_reg;
        inst_valid <= 1'b1;
        pc_reg     <= npc;
      end else if (inst_ready) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL provide parameter EXC_VECTOR, 32'h00000050, exception/interrupt handler entry address.
REQ-003 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous active-low reset (0 = reset, sampled on rising clk edge).
REQ-005 SHALL provide port stall  input  1  hold PC and output register this cycle.
REQ-006 SHALL provide port except_en  input  1  redirect to EXC_VECTOR.
REQ-007 SHALL provide port eret_en  input  1  redirect to epc.
REQ-008 SHALL provide port epc  input  32  return address for eret.
REQ-009 SHALL provide port jump_en  input  1  redirect to jump_addr (j/jal/jr/jalr).
REQ-010 SHALL provide port jump_addr  input  32  jump target.
REQ-011 SHALL provide port branch_en  input  1  redirect to branch_addr (taken branch).
REQ-012 SHALL provide port branch_addr  input  32  branch target.
REQ-013 SHALL provide port rom_ce  output  1  instruction-memory chip enable (1 = enabled).
REQ-014 SHALL provide port rom_addr  output  32  instruction-memory byte address (= current PC).
REQ-015 SHALL provide port rom_data  input  32  combinational instruction word returned by memory.
REQ-016 SHALL provide port inst  output  32  registered instruction to decode.
REQ-017 SHALL provide port inst_pc  output  32  address of inst.
REQ-018 SHALL provide port inst_valid  output  1  inst holds a valid instruction.
REQ-019 SHALL provide port inst_ready  input  1  decode accepts inst this cycle.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, HOLD; reset enters IDLE.
REQ-021 SHALL hold IDLE for exactly one cycle after rst deasserts with rom_ce=0, then enter RUN.
REQ-022 SHALL drive rom_ce=1 in RUN and HOLD; rom_addr SHALL equal pc in all states.
REQ-023 SHALL define capture = RUN && !stall && (!inst_valid || inst_ready).
REQ-024 On capture SHALL register inst<=rom_data, inst_pc<=pc, inst_valid<=1, pc<=next_pc (one-cycle fetch latency).
REQ-025 SHALL select next_pc by priority except_en > eret_en > jump_en > branch_en > pc+4.
REQ-026 SHALL force bits [1:0] of any redirect target to 00.
REQ-027 SHALL compute pc+4 modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
REQ-028 SHALL apply any redirect in the cycle it is asserted regardless of stall, HOLD or inst_ready, and SHALL clear inst_valid that cycle (flush).
REQ-029 SHALL enter HOLD from RUN when stall=1 or (inst_valid && !inst_ready) and no redirect; pc, inst, inst_pc SHALL stay unchanged in HOLD.
REQ-030 SHALL return HOLD->RUN on the cycle the hold condition is false or a redirect occurs.
REQ-031 SHALL clear inst_valid when inst_ready=1 and no capture occurs that cycle.
REQ-032 SHALL ignore redirect inputs during IDLE and reset.

Reset
REQ-033 While rst=0 at a clock edge SHALL set pc=RESET_PC, inst=32'h0, inst_pc=32'h0, inst_valid=0, rom_ce=0, state=IDLE.
REQ-034 Reset mid-operation SHALL discard any held instruction and pending redirect.

Structure
REQ-035 SHALL place FSM state encodings, RESET_PC/EXC_VECTOR defaults, enable levels (RomEnable/RomDisable) and 32'h0 Zero in the shared define include.
REQ-036 SHALL implement next-PC selection as sub-module npc_sel (combinational, priority mux plus alignment); FSM and registers stay in fetch_ctrl.

Verification
REQ-037 Reset release, inst_ready=1, rom_data=f(addr) -> rom_ce=0 one cycle, then inst_pc sequence 0x0,0x4,0x8 with inst_valid=1 from third post-reset edge.
REQ-038 jump_en=1, jump_addr=0x10 while pc=0x18 -> next rom_addr=0x10, inst_valid=0 that cycle, next inst_pc=0x10.
REQ-039 except_en=1 and jump_en=1 same cycle -> pc=0x50; later eret_en=1, epc=0x1B -> pc=0x18.
REQ-040 inst_ready=0 for 3 cycles with inst_valid=1 -> inst/inst_pc/pc frozen, FSM HOLD; inst_ready=1 -> next sequential fetch resumes without skip or duplicate.
REQ-041 pc forced to 0xFFFFFFFC via branch -> following fetch address 0x00000000.
REQ-042 rst=0 asserted during HOLD -> next edge pc=RESET_PC, inst_valid=0, rom_ce=0.
